decode_issue: RTL and testbench

// Decode/issue stage directly upstream of RegisterFile. Accepts fetched instructions over a

---
 rtl/decode_issue_if.sv | 28 ++
 rtl/decode_issue.sv | 89 ++++++++
 tb/tb_decode_issue.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/decode_issue_if.sv
// Fetch-to-decode and decode-to-execute valid/ready bundles.
// The master side drives fetch data and consumes the issue slot.
interface decode_issue_if #(
    parameter int INSTR_W = 24
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [5:0]         out_opcode;
    logic [7:0]         out_a1;
    logic [7:0]         out_a2;
    logic [7:0]         out_a3;
    logic               out_we;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_opcode,
        input  out_a1, out_a2, out_a3, out_we
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_opcode,
        output out_a1, out_a2, out_a3, out_we
    );
endinterface

// File: rtl/decode_issue.sv
// Decode/issue stage: splits instructions into RegisterFile addresses,
// tracks in-flight writes in a scoreboard and stalls on RAW/WAW hazards.
module decode_issue #(
    parameter int INSTR_W = 24,
    parameter int NREGS   = 32
) (
    input  logic              clk,
    input  logic              reset,
    decode_issue_if.slave     bus,
    input  logic              wb_valid,
    input  logic [7:0]        wb_addr,
    input  logic              flush,
    output logic [5:0]        pending_cnt
);
    logic [NREGS-1:0] sb;
    logic [NREGS-1:0] sb_next;
    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] pend_eff;
    logic [5:0]       opcode;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             nop;
    logic             we;
    logic             hazard;
    logic             accept;
    logic [5:0]       cnt_next;

    assign opcode = bus.in_instr[INSTR_W-1 -: 6];
    assign rd     = bus.in_instr[17:13];
    assign rs1    = bus.in_instr[12:8];
    assign rs2    = bus.in_instr[7:3];
    assign nop    = (opcode == 6'h00);
    assign we     = ~nop & ~opcode[5];

    // A retire this cycle lands in the RegisterFile at the same edge,
    // so it already unblocks a waiting consumer.
    assign clr_mask = wb_valid ? (NREGS'(1) << wb_addr[4:0]) : '0;
    assign pend_eff = sb & ~clr_mask;

    assign hazard = ~nop & (pend_eff[rs1] | pend_eff[rs2] | (we & pend_eff[rd]));

    assign bus.in_ready = ~reset & ~flush & ~hazard &
                          (~bus.out_valid | bus.out_ready);
    assign accept   = bus.in_valid & bus.in_ready;
    assign set_mask = (accept & we) ? (NREGS'(1) << rd) : '0;
    assign sb_next  = pend_eff | set_mask;

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_next = cnt_next + 6'(sb_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb          <= '0;
            pending_cnt <= '0;
        end else begin
            sb          <= sb_next;
            pending_cnt <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid  <= 1'b0;
            bus.out_opcode <= '0;
            bus.out_a1     <= '0;
            bus.out_a2     <= '0;
            bus.out_a3     <= '0;
            bus.out_we     <= 1'b0;
        end else if (flush) begin
            bus.out_valid <= 1'b0;
            bus.out_we    <= 1'b0;
        end else if (accept) begin
            bus.out_valid  <= 1'b1;
            bus.out_opcode <= opcode;
            bus.out_a1     <= {3'b000, rs1};
            bus.out_a2     <= {3'b000, rs2};
            bus.out_a3     <= {3'b000, rd};
            bus.out_we     <= we;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue with an issue-order scoreboard queue.
// Inputs change 1 time unit after posedge; issue slot is sampled at negedge.
module tb_decode_issue;
    logic       clk = 1'b0;
    logic       reset;
    logic       wb_valid;
    logic [7:0] wb_addr;
    logic       flush;
    logic [5:0] pending_cnt;

    int checks = 0;
    int errors = 0;

    logic [30:0] exp_q[$];

    decode_issue_if bus ();

    decode_issue dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .flush      (flush),
        .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    function automatic logic [30:0] rec(input logic [23:0] ins);
        logic [5:0] op;
        logic       w;
        op = ins[23:18];
        w  = (op != 6'h00) && !op[5];
        return {op, 3'b000, ins[12:8], 3'b000, ins[7:3], 3'b000, ins[17:13], w};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction; expect acceptance or a stall this cycle.
    task automatic offer(input string tag, input logic [23:0] ins, input logic acc);
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        #1;
        chk(tag, 32'(bus.in_ready), 32'(acc));
        if (acc) exp_q.push_back(rec(ins));
    endtask

    always @(negedge clk) begin
        if (!reset && bus.out_valid) begin
            if (flush) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else if (bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("issue_unexpected", 32'(1), 32'(0));
                end else begin
                    chk("issue_fields",
                        32'({bus.out_opcode, bus.out_a1, bus.out_a2, bus.out_a3, bus.out_we}),
                        32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instr  = mk(6'h01, 5'd3, 5'd1, 5'd2);
        bus.out_ready = 1'b1;
        wb_valid      = 1'b0;
        wb_addr       = '0;
        flush         = 1'b0;
        #1;
        chk("reset_in_ready", 32'(bus.in_ready), 32'(0));
        cyc();
        cyc();
        chk("reset_out_valid", 32'(bus.out_valid), 32'(0));
        chk("reset_pending", 32'(pending_cnt), 32'(0));
        chk("reset_a3_we", 32'({bus.out_a3, bus.out_we}), 32'(0));
        reset = 1'b0;
        bus.in_valid = 1'b0;
        cyc();

        // RAW on r3, released by same-cycle writeback
        offer("raw_first", mk(6'h01, 5'd3, 5'd1, 5'd2), 1'b1);
        cyc();
        bus.in_valid = 1'b0;
        chk("raw_a3", 32'(bus.out_a3), 32'h03);
        chk("raw_we", 32'(bus.out_we), 32'(1));
        chk("raw_pending1", 32'(pending_cnt), 32'(1));
        offer("raw_stall0", mk(6'h01, 5'd9, 5'd3, 5'd0), 1'b0);
        cyc();
        offer("raw_stall1", mk(6'h01, 5'd9, 5'd3, 5'd0), 1'b0);
        cyc();
        wb_valid = 1'b1;
        wb_addr  = 8'd3;
        offer("raw_release", mk(6'h01, 5'd9, 5'd3, 5'd0), 1'b1);
        cyc();
        bus.in_valid = 1'b0;
        wb_valid = 1'b0;
        chk("raw_pending_swap", 32'(pending_cnt), 32'(1));
        wb_valid = 1'b1;
        wb_addr  = 8'hE9;
        cyc();
        wb_valid = 1'b0;
        chk("wb_upper_bits_ignored", 32'(pending_cnt), 32'(0));

        // back-to-back independent writes
        for (int i = 0; i < 8; i++) begin
            offer("b2b_accept", mk(6'h02, 5'(4 + i), 5'd0, 5'd1), 1'b1);
            cyc();
        end
        chk("b2b_pending8", 32'(pending_cnt), 32'(8));
        bus.out_ready = 1'b0;
        bus.in_instr  = mk(6'h02, 5'd12, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 32'(bus.in_ready), 32'(0));
            chk("bp_out_stable",
                32'({bus.out_valid, bus.out_opcode, bus.out_a3, bus.out_we}),
                32'({1'b1, 6'h02, 8'd11, 1'b1}));
            cyc();
        end
        bus.out_ready = 1'b1;
        offer("bp_release", mk(6'h02, 5'd12, 5'd0, 5'd0), 1'b1);
        cyc();
        bus.in_valid = 1'b0;
        chk("bp_pending9", 32'(pending_cnt), 32'(9));
        for (int r = 4; r <= 12; r++) begin
            if (r != 5) begin
                wb_valid = 1'b1;
                wb_addr  = 8'(r);
                cyc();
            end
        end
        wb_valid = 1'b0;
        chk("retire_pending1", 32'(pending_cnt), 32'(1));

        // WAW on r5 stalls a write but not a non-writing op
        offer("waw_stall", mk(6'h01, 5'd5, 5'd0, 5'd0), 1'b0);
        cyc();
        offer("waw_stall2", mk(6'h01, 5'd5, 5'd0, 5'd0), 1'b0);
        cyc();
        offer("waw_nowrite", mk(6'h20, 5'd5, 5'd0, 5'd0), 1'b1);
        cyc();
        bus.in_valid = 1'b0;
        chk("waw_we0", 32'(bus.out_we), 32'(0));
        chk("waw_pending", 32'(pending_cnt), 32'(1));
        offer("nop_ignores_hazard", mk(6'h00, 5'd5, 5'd5, 5'd5), 1'b1);
        cyc();
        bus.in_valid = 1'b0;

        // same-cycle set and clear of r7: set wins
        offer("set7", mk(6'h01, 5'd7, 5'd0, 5'd0), 1'b1);
        cyc();
        bus.in_valid = 1'b0;
        chk("set7_pending", 32'(pending_cnt), 32'(2));
        wb_valid = 1'b1;
        wb_addr  = 8'd7;
        offer("setclr7", mk(6'h01, 5'd7, 5'd0, 5'd0), 1'b1);
        cyc();
        bus.in_valid = 1'b0;
        wb_valid = 1'b0;
        chk("setclr7_pending", 32'(pending_cnt), 32'(2));
        offer("r7_still_set", mk(6'h01, 5'd1, 5'd7, 5'd0), 1'b0);
        cyc();
        bus.in_valid = 1'b0;
        wb_valid = 1'b1;
        wb_addr  = 8'd20;
        cyc();
        wb_valid = 1'b0;
        chk("wb_clear_bit_noop", 32'(pending_cnt), 32'(2));

        // flush with a held slot and a pending input
        bus.out_ready = 1'b0;
        offer("flush_fill", mk(6'h02, 5'd8, 5'd0, 5'd0), 1'b1);
        cyc();
        chk("flush_pre_valid", 32'(bus.out_valid), 32'(1));
        chk("flush_pre_pending", 32'(pending_cnt), 32'(3));
        flush = 1'b1;
        offer("flush_in_ready", mk(6'h02, 5'd9, 5'd0, 5'd0), 1'b0);
        cyc();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("flush_out_valid", 32'(bus.out_valid), 32'(0));
        chk("flush_out_we", 32'(bus.out_we), 32'(0));
        chk("flush_pending", 32'(pending_cnt), 32'(3));
        cyc();

        // reset mid-operation ignores writeback
        reset    = 1'b1;
        wb_valid = 1'b1;
        wb_addr  = 8'd5;
        cyc();
        reset    = 1'b0;
        wb_valid = 1'b0;
        chk("midreset_pending", 32'(pending_cnt), 32'(0));
        chk("midreset_valid", 32'(bus.out_valid), 32'(0));
        offer("midreset_r5_free", mk(6'h01, 5'd5, 5'd7, 5'd8), 1'b1);
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        cyc();
        chk("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
